// File: rtl/ptr_sync_cmp.sv
// Gray pointer synchronizer with registered binary conversion and empty/full/level compare.
// Optional Gray-change error checker is built when PTR_SYNC_ERR_DET_EN is defined.
module ptr_sync_cmp #(
  parameter int ASIZE  = 4,
  parameter int STAGES = 2,
  parameter int MODE   = 0
) (
  input  logic             c_clk,
  input  logic             c_rst,
  input  logic [ASIZE:0]   ptr_g_in,
  input  logic [ASIZE:0]   local_ptr_b,
  output logic [ASIZE:0]   sync_ptr_g,
  output logic [ASIZE:0]   sync_ptr_b,
  output logic             upd,
  output logic             flag,
  output logic [ASIZE:0]   level,
  output logic             err,
  output logic [7:0]       err_cnt
);

  localparam logic [ASIZE:0] ONE = {{ASIZE{1'b0}}, 1'b1};

  function automatic logic [ASIZE:0] gray2bin(input logic [ASIZE:0] g);
    logic [ASIZE:0] b;
    b[ASIZE] = g[ASIZE];
    for (int i = ASIZE - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Clearing the lowest set bit leaves something only if two or more bits were set.
  function automatic logic multi_bit(input logic [ASIZE:0] d);
    return (d & (d - ONE)) != '0;
  endfunction

  logic [ASIZE:0] sync_r [STAGES];
  logic [ASIZE:0] prev_r;
  logic [ASIZE:0] bin_r;

  // synchronizer chain, prior-value register and binary conversion register
  always_ff @(posedge c_clk or negedge c_rst) begin
    if (!c_rst) begin
      for (int k = 0; k < STAGES; k++) begin
        sync_r[k] <= '0;
      end
      prev_r <= '0;
      bin_r  <= '0;
    end else begin
      sync_r[0] <= ptr_g_in;
      for (int k = 1; k < STAGES; k++) begin
        sync_r[k] <= sync_r[k-1];
      end
      prev_r <= sync_r[STAGES-1];
      bin_r  <= gray2bin(sync_r[STAGES-1]);
    end
  end

  assign sync_ptr_g = sync_r[STAGES-1];
  assign sync_ptr_b = bin_r;
  assign upd        = (sync_r[STAGES-1] != prev_r);

  // same-cycle occupancy and empty/full flag from converted remote and local pointer
  always_comb begin
    level = '0;
    flag  = 1'b0;
    if (MODE == 0) begin
      level = bin_r - local_ptr_b;
      flag  = (bin_r == local_ptr_b);
    end else begin
      level = local_ptr_b - bin_r;
      flag  = (bin_r[ASIZE] != local_ptr_b[ASIZE]) &&
              (bin_r[ASIZE-1:0] == local_ptr_b[ASIZE-1:0]);
    end
  end

`ifdef PTR_SYNC_ERR_DET_EN
  logic [7:0] cnt_r;

  assign err = multi_bit(sync_r[STAGES-1] ^ prev_r);

  // saturating count of illegal Gray transitions
  always_ff @(posedge c_clk or negedge c_rst) begin
    if (!c_rst) begin
      cnt_r <= 8'd0;
    end else if (err && (cnt_r != 8'hFF)) begin
      cnt_r <= cnt_r + 8'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign err_cnt = cnt_r;
`else
  assign err     = 1'b0;
  assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_ptr_sync_cmp.sv
// Scoreboard bench for ptr_sync_cmp (ASIZE=4, STAGES=2): MODE 0 instance checked by
// queue monitor plus directed latency checks; MODE 1 instance checked directly.
module tb_ptr_sync_cmp;

  typedef struct {
    logic [4:0] g;
    logic       e;
  } upd_exp_t;

  typedef struct {
    logic [4:0] b;
    logic [4:0] lvl;
    logic       flg;
  } bin_exp_t;

`ifdef PTR_SYNC_ERR_DET_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       c_clk = 1'b0;
  logic       c_rst;
  logic [4:0] ptr_g_in;
  logic [4:0] local0, local1;
  logic [4:0] sg0, sb0, lvl0, sg1, sb1, lvl1;
  logic       upd0, flg0, err0, upd1, flg1, err1;
  logic [7:0] ecnt0, ecnt1;
  logic       upd_d = 1'b0;

  int total = 0;
  int bad   = 0;
  upd_exp_t q_upd[$];
  bin_exp_t q_bin[$];

  ptr_sync_cmp #(.ASIZE(4), .STAGES(2), .MODE(0)) dut0 (
    .c_clk(c_clk), .c_rst(c_rst), .ptr_g_in(ptr_g_in), .local_ptr_b(local0),
    .sync_ptr_g(sg0), .sync_ptr_b(sb0), .upd(upd0), .flag(flg0), .level(lvl0),
    .err(err0), .err_cnt(ecnt0)
  );

  ptr_sync_cmp #(.ASIZE(4), .STAGES(2), .MODE(1)) dut1 (
    .c_clk(c_clk), .c_rst(c_rst), .ptr_g_in(ptr_g_in), .local_ptr_b(local1),
    .sync_ptr_g(sg1), .sync_ptr_b(sb1), .upd(upd1), .flag(flg1), .level(lvl1),
    .err(err1), .err_cnt(ecnt1)
  );

  always #5 c_clk = ~c_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge c_clk);
    #1;
  endtask

  task automatic push(input logic [4:0] g, input logic [4:0] b, input logic e);
    upd_exp_t u;
    bin_exp_t x;
    u.g = g;
    u.e = e;
    x.b = b;
    x.lvl = b - local0;
    x.flg = (b == local0);
    q_upd.push_back(u);
    q_bin.push_back(x);
  endtask

  always @(posedge c_clk) upd_d <= upd0;

  // monitor: gray/err when upd pulses, binary/level/flag one cycle later
  always @(negedge c_clk) begin
    if (upd0) begin
      if (q_upd.size() == 0) begin
        total++;
        bad++;
        $display("FAIL upd_unexpected: got upd=1 with sync_ptr_g=%0h, expected no update", sg0);
      end else begin
        upd_exp_t u;
        u = q_upd.pop_front();
        chk("mon_sync_g", {27'd0, sg0}, {27'd0, u.g});
        chk("mon_err", {31'd0, err0}, {31'd0, u.e});
      end
    end
    if (upd_d && q_bin.size() != 0) begin
      bin_exp_t x;
      x = q_bin.pop_front();
      chk("mon_sync_b", {27'd0, sb0}, {27'd0, x.b});
      chk("mon_level", {27'd0, lvl0}, {27'd0, x.lvl});
      chk("mon_flag", {31'd0, flg0}, {31'd0, x.flg});
    end
  end

  initial begin
    logic [4:0] b;
    int cnt_m;
    c_rst    = 1'b0;
    ptr_g_in = 5'h1F;
    local0   = 5'd0;
    local1   = 5'd0;
    tick(3);
    chk("rst_sync_g", {27'd0, sg0}, 32'd0);
    chk("rst_sync_b", {27'd0, sb0}, 32'd0);
    chk("rst_level", {27'd0, lvl0}, 32'd0);
    chk("rst_flag0", {31'd0, flg0}, 32'd1);
    chk("rst_upd", {31'd0, upd0}, 32'd0);
    chk("rst_err", {31'd0, err0}, 32'd0);
    chk("rst_err_cnt", {24'd0, ecnt0}, 32'd0);
    chk("rst_flag1", {31'd0, flg1}, 32'd0);
    chk("rst_level1", {27'd0, lvl1}, 32'd0);

    ptr_g_in = 5'd0;
    c_rst    = 1'b1;
    tick(3);
    local1 = 5'b10000;
    #1;
    chk("m1_full_flag", {31'd0, flg1}, 32'd1);
    chk("m1_full_level", {27'd0, lvl1}, 32'd16);
    chk("idle_sync_g", {27'd0, sg0}, 32'd0);

    // single-bit step: latency of the gray and binary paths
    ptr_g_in = 5'b00001;
    push(5'd1, 5'd1, 1'b0);
    tick(1);
    chk("lat_g_n1", {27'd0, sg0}, 32'd0);
    tick(1);
    chk("lat_g_n2", {27'd0, sg0}, 32'd1);
    chk("lat_upd_n2", {31'd0, upd0}, 32'd1);
    chk("lat_b_n2", {27'd0, sb0}, 32'd0);
    tick(1);
    chk("lat_b_n3", {27'd0, sb0}, 32'd1);
    chk("lat_level_n3", {27'd0, lvl0}, 32'd1);
    chk("lat_flag_n3", {31'd0, flg0}, 32'd0);
    chk("lat_upd_n3", {31'd0, upd0}, 32'd0);
    chk("m1_level_15", {27'd0, lvl1}, 32'd15);
    chk("m1_flag_0", {31'd0, flg1}, 32'd0);

    // walk the remote pointer up to binary 31
    for (int i = 2; i < 32; i++) begin
      b = 5'(i);
      ptr_g_in = b ^ (b >> 1);
      push(b ^ (b >> 1), b, 1'b0);
      tick(4);
    end
    chk("walk_sync_g_31", {27'd0, sg0}, 32'h10);
    local0 = 5'd31;
    #1;
    chk("local_same_cycle_flag", {31'd0, flg0}, 32'd1);
    chk("local_same_cycle_level", {27'd0, lvl0}, 32'd0);

    // wrap 31 -> 0 is a legal single-bit change
    ptr_g_in = 5'b00000;
    push(5'd0, 5'd0, 1'b0);
    tick(3);
    chk("wrap_err", {31'd0, err0}, 32'd0);
    chk("wrap_sync_b", {27'd0, sb0}, 32'd0);
    chk("wrap_level", {27'd0, lvl0}, 32'd1);
    chk("wrap_err_cnt", {24'd0, ecnt0}, 32'd0);
    tick(1);
    chk("m1_wrap_flag", {31'd0, flg1}, 32'd1);
    chk("m1_wrap_level", {27'd0, lvl1}, 32'd16);

    // illegal two-bit Gray change
    local0 = 5'd0;
    #1;
    chk("local0_zero_flag", {31'd0, flg0}, 32'd1);
    ptr_g_in = 5'b00011;
    push(5'd3, 5'd2, ERR_EN);
    tick(2);
    chk("err_pulse", {31'd0, err0}, {31'd0, ERR_EN});
    chk("err_upd", {31'd0, upd0}, 32'd1);
    tick(1);
    chk("err_one_cycle", {31'd0, err0}, 32'd0);
    chk("err_cnt_1", {24'd0, ecnt0}, {31'd0, ERR_EN});
    chk("err_sync_b", {27'd0, sb0}, 32'd2);
    cnt_m = ERR_EN ? 1 : 0;

    for (int i = 0; i < 300; i++) begin
      ptr_g_in = (i % 2 == 0) ? 5'b00000 : 5'b00011;
      push(ptr_g_in, (i % 2 == 0) ? 5'd0 : 5'd2, ERR_EN);
      tick(3);
      if (ERR_EN && cnt_m < 255) cnt_m++;
      if (i == 252) chk("err_cnt_254", {24'd0, ecnt0}, 32'(cnt_m));
    end
    chk("err_cnt_sat", {24'd0, ecnt0}, 32'(cnt_m));

    // move to binary 5 (2 -> 3 -> 4 -> 5) then pulse reset between edges
    ptr_g_in = 5'b00010; push(5'b00010, 5'd3, 1'b0); tick(4);
    ptr_g_in = 5'b00110; push(5'b00110, 5'd4, 1'b0); tick(4);
    ptr_g_in = 5'b00111; push(5'b00111, 5'd5, 1'b0); tick(4);
    chk("pre_rst_level", {27'd0, lvl0}, 32'd5);
    chk("pre_rst_flag", {31'd0, flg0}, 32'd0);
    #2;
    c_rst = 1'b0;
    #1;
    chk("arst_sync_g", {27'd0, sg0}, 32'd0);
    chk("arst_sync_b", {27'd0, sb0}, 32'd0);
    chk("arst_level", {27'd0, lvl0}, 32'd0);
    chk("arst_flag", {31'd0, flg0}, 32'd1);
    chk("arst_upd", {31'd0, upd0}, 32'd0);
    chk("arst_err_cnt", {24'd0, ecnt0}, 32'd0);
    chk("arst_m1_level", {27'd0, lvl1}, 32'd16);
    tick(3);
    chk("q_upd_drained", 32'(q_upd.size()), 32'd0);
    chk("q_bin_drained", 32'(q_bin.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ptr_sync_cmp.md
PTR_SYNC_CMP -- requirements
Module: ptr_sync_cmp

Interface
REQ-001 Parameter ASIZE, default 4: FIFO address bits; pointers are ASIZE+1 bits wide.
REQ-002 Parameter STAGES, default 2: synchronizer flop count; legal range 2..4.
REQ-003 Parameter MODE, default 0: 0 = read side (remote = write ptr, empty flag); 1 = write side (remote = read ptr, full flag).
REQ-004 c_clk  in  1  sole clock; all flops rise on posedge c_clk.
REQ-005 c_rst  in  1  asynchronous active-low reset.
REQ-006 ptr_g_in  in  ASIZE+1  Gray-coded remote pointer, asynchronous to c_clk.
REQ-007 local_ptr_b  in  ASIZE+1  binary local pointer, synchronous to c_clk.
REQ-008 sync_ptr_g  out  ASIZE+1  synchronized Gray pointer (last sync stage).
REQ-009 sync_ptr_b  out  ASIZE+1  registered binary conversion of sync_ptr_g.
REQ-010 upd  out  1  one-cycle pulse when sync_ptr_g changes.
REQ-011 flag  out  1  empty (MODE 0) or full (MODE 1).
REQ-012 level  out  ASIZE+1  FIFO occupancy, 0..2^ASIZE.
REQ-013 err  out  1  one-cycle pulse on an illegal multi-bit Gray change.
REQ-014 err_cnt  out  8  saturating error count.

Function
REQ-015 Stage 1 shall capture ptr_g_in; stage k shall capture stage k-1; sync_ptr_g shall be stage STAGES.
REQ-016 Latency: sync_ptr_g shall reflect a stable ptr_g_in after STAGES edges; sync_ptr_b after STAGES+1 edges.
REQ-017 sync_ptr_b shall be registered: b[ASIZE]=g[ASIZE], b[i]=b[i+1]^g[i], computed from sync_ptr_g.
REQ-018 A previous-value register shall hold sync_ptr_g from the prior cycle; upd shall be 1 for exactly the cycle in which they differ.
REQ-019 MODE 0: level = sync_ptr_b - local_ptr_b, modulo 2^(ASIZE+1); flag = 1 when sync_ptr_b == local_ptr_b.
REQ-020 MODE 1: level = local_ptr_b - sync_ptr_b, modulo 2^(ASIZE+1); flag = 1 when the MSBs differ and the lower ASIZE bits are equal.
REQ-021 flag and level shall be combinational from sync_ptr_b and local_ptr_b, so that a local pointer update is reflected in the same cycle.
REQ-022 Wrap-around of either pointer, e.g. 2^(ASIZE+1)-1 to 0, shall be a legal single-bit Gray change and shall produce correct modular level.
REQ-023 Hamming distance between sync_ptr_g and its prior value >1 shall assert err for one cycle, concurrent with upd.
REQ-024 err_cnt shall increment on each err pulse and saturate at 255.
REQ-025 A change on ptr_g_in shorter than one c_clk period need not be captured; no output other than sync_ptr_g, sync_ptr_b, upd, flag, level, err and err_cnt shall depend on it.

Reset
REQ-026 c_rst low shall clear every sync stage, the prior-value register, sync_ptr_b and err_cnt immediately, without a clock edge.
REQ-027 During reset: upd=0, err=0, level = MODE 0 ? 0-local : local (local_ptr_b expected 0, giving level 0); flag=1 for MODE 0, 0 for MODE 1.
REQ-028 After c_rst deasserts, the first sync stage shall load on the next posedge.

Configuration
REQ-029 Macro PTR_SYNC_ERR_DET_EN: when defined, REQ-023/REQ-024 logic shall be built.
REQ-030 Without PTR_SYNC_ERR_DET_EN: err and err_cnt shall be tied to 0; the ports shall remain present; all other behaviour shall be unchanged.

Verification (ASIZE=4, STAGES=2)
REQ-031 c_rst=0, ptr_g_in=5'h1F, clock running -> sync_ptr_g=0, sync_ptr_b=0, level=0, flag=1 (MODE 0).
REQ-032 MODE 0, local=0, ptr_g_in 0->5'b00001 at edge N -> sync_ptr_g=1 after N+2, sync_ptr_b=1 and level=1 after N+3, flag=0, upd pulses at N+2 only.
REQ-033 MODE 1, local=5'b10000, ptr_g_in=0 -> flag=1, level=16; then ptr_g_in=5'b00001 -> flag=0 and level=15 three edges later.
REQ-034 Remote binary 31 (Gray 5'b10000) -> 0 (Gray 5'b00000), local=31 (MODE 0) -> err=0, sync_ptr_b=0, level=1.
REQ-035 Macro on, ptr_g_in 5'b00000 -> 5'b00011 held -> err=1 for exactly one cycle, err_cnt=1; 300 such events -> err_cnt=255; macro off -> err=0, err_cnt=0.
REQ-036 With level=5, c_rst pulsed low between edges -> all registers clear asynchronously, flag=1 (MODE 0) before the next posedge.
